// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: shared access-size and LSU FSM state types
package lsu_mem_port_pkg;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10} size_e;
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_e;
endpackage

// File: rtl/lsu_mem_port_align.sv
// lsu_lane_align: little-endian lane extract/extend, sub-word store merge, alignment check
module lsu_lane_align
    import lsu_mem_port_pkg::*;
(
    input  size_e             size,
    input  logic [1:0]        lsb,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged,
    output logic              bad
);
    logic [4:0]        sh;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;
    assign sh = size == SIZE_B ? {lsb, 3'b000} : {lsb[1], 4'b0000};
    assign lane = rdata >> sh;
    assign mask = size == SIZE_B ? 32'h0000_00ff : 32'h0000_ffff;
    assign load_data = size == SIZE_B ? {{24{~is_unsigned & lane[7]}}, lane[7:0]} :
                       size == SIZE_H ? {{16{~is_unsigned & lane[15]}}, lane[15:0]} : rdata;
    assign merged = (rdata & ~(mask << sh)) | ((wdata & mask) << sh);
    assign bad = size == SIZE_H ? lsb[0] : size == SIZE_W ? |lsb : size != SIZE_B;
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store requests to a one-cycle-latency single-port word memory
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              write_enable,
    output logic              read_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] input_data,
    input  logic [DATA_W-1:0] output_data
);
    if (DATA_W != 32) begin : g_bad_width
        $error("lsu_mem_port supports only DATA_W = 32");
    end

    state_e            state, nxt;
    size_e             size_q, sel_size;
    logic              st_q, uns_q, err_q, accept, bad, err;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        sel_lsb;
    logic [DATA_W-1:0] wdata_q, data_q, load_data, merged;

    // Alignment is checked on the live request in IDLE, lanes use the latched one after.
    assign accept = state == IDLE && req_valid;
    assign sel_size = state == IDLE ? size_e'(req_size) : size_q;
    assign sel_lsb = state == IDLE ? req_addr[1:0] : addr_q[1:0];
    assign err = bad | (|req_addr[31:ADDR_W+2]);

    lsu_lane_align u_align (
        .size        (sel_size),
        .lsb         (sel_lsb),
        .is_unsigned (uns_q),
        .rdata       (output_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged),
        .bad         (bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                st_q    <= req_store;
                uns_q   <= req_unsigned;
                err_q   <= err;
                size_q  <= size_e'(req_size);
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
            end
            if (state == WAIT) data_q <= st_q ? merged : load_data;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req_valid) nxt = err ? RESP : (req_store && req_size == SIZE_W) ? WRITE : READ;
            READ:    nxt = WAIT;
            WAIT:    nxt = st_q ? WRITE : RESP;
            WRITE:   nxt = RESP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = state == IDLE;
        read_enable  = state == READ;
        write_enable = state == WRITE;
        input_data   = state == WRITE ? (size_q == SIZE_W ? wdata_q : data_q) : '0;
        rsp_valid    = state == RESP;
        rsp_error    = state == RESP && err_q;
        rsp_rdata    = (state == RESP && !st_q && !err_q) ? data_q : '0;
    end

    assign address = addr_q[ADDR_W+1:2];
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed scoreboard bench with a behavioural one-cycle-latency memory
module tb_lsu_mem_port;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic [31:0]   req_addr = '0, req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_error, write_enable, read_enable;
    logic [31:0]   rsp_rdata, input_data;
    logic [31:0]   output_data = '0;
    logic [AW-1:0] address;
    logic [31:0]   mem [1024];

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .address      (address),
        .input_data   (input_data),
        .output_data  (output_data)
    );

    always @(posedge clk) begin
        if (write_enable) mem[address] <= input_data;
        if (read_enable) output_data <= write_enable ? input_data : mem[address];
    end

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        er;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          cyc = 0, n_cmp = 0, n_err = 0, rsp_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic [31:0] last_wa = '0, last_wd = '0, last_ra = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) acc_q.delete();
        else if (req_valid && req_ready) acc_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if (read_enable) begin
            rd_cnt++;
            last_ra = 32'(address);
        end
        if (write_enable) begin
            wr_cnt++;
            last_wa = 32'(address);
            last_wd = input_data;
        end
        if (rsp_valid) begin : mon
            exp_t e;
            int   a;
            rsp_cnt++;
            chk("rsp_expected", 32'(exp_q.size() != 0 && acc_q.size() != 0), 32'd1);
            if (exp_q.size() != 0 && acc_q.size() != 0) begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk({e.tag, "_rdata"}, rsp_rdata, e.rd);
                chk({e.tag, "_err"}, 32'(rsp_error), 32'(e.er));
                chk({e.tag, "_lat"}, 32'(cyc - a), 32'(e.lat));
            end
        end
    end

    task automatic send(input string tag, input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_er, input int lat, input int nrd, input int nwr);
        int r0, w0, s0, k;
        @(negedge clk);
        r0 = rd_cnt;
        w0 = wr_cnt;
        s0 = rsp_cnt;
        req_valid = 1'b1;
        req_store = st;
        req_size = sz;
        req_unsigned = un;
        req_addr = a;
        req_wdata = wd;
        exp_q.push_back('{tag, exp_rd, exp_er, lat});
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_acc"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_store = 1'($urandom);
        req_size = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        k = 0;
        while (rsp_cnt == s0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_done"}, 32'(rsp_cnt - s0), 32'd1);
        chk({tag, "_rd_en"}, 32'(rd_cnt - r0), 32'(nrd));
        chk({tag, "_wr_en"}, 32'(wr_cnt - w0), 32'(nwr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s0, w0, k;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #12;
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_re", 32'(read_enable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_error), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_wdata", input_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);

        send("sw8", 1, 2'b10, 0, 32'h8, 32'h0000_0008, 32'h0, 0, 2, 0, 1);
        chk("sw8_waddr", last_wa, 32'd2);
        chk("sw8_wdata", last_wd, 32'h0000_0008);
        send("lw8", 0, 2'b10, 0, 32'h8, 32'h0, 32'h0000_0008, 0, 3, 1, 0);
        chk("lw8_raddr", last_ra, 32'd2);
        send("sw14", 1, 2'b10, 0, 32'h14, 32'h1234_80ff, 32'h0, 0, 2, 0, 1);
        send("lb15s", 0, 2'b00, 0, 32'h15, 32'h0, 32'hffff_ff80, 0, 3, 1, 0);
        send("lb15u", 0, 2'b00, 1, 32'h15, 32'h0, 32'h0000_0080, 0, 3, 1, 0);
        send("lh16s", 0, 2'b01, 0, 32'h16, 32'h0, 32'h0000_1234, 0, 3, 1, 0);
        send("lh14s", 0, 2'b01, 0, 32'h14, 32'h0, 32'hffff_80ff, 0, 3, 1, 0);
        send("lh14u", 0, 2'b01, 1, 32'h14, 32'h0, 32'h0000_80ff, 0, 3, 1, 0);
        send("lb14s", 0, 2'b00, 0, 32'h14, 32'h0, 32'hffff_ffff, 0, 3, 1, 0);
        send("sb16", 1, 2'b00, 0, 32'h16, 32'hffff_ffab, 32'h0, 0, 4, 1, 1);
        chk("sb16_waddr", last_wa, 32'd5);
        chk("sb16_wdata", last_wd, 32'h12ab_80ff);
        send("lw14", 0, 2'b10, 0, 32'h14, 32'h0, 32'h12ab_80ff, 0, 3, 1, 0);
        send("sh0a", 1, 2'b01, 0, 32'h0a, 32'hffff_5a5a, 32'h0, 0, 4, 1, 1);
        chk("sh0a_wdata", last_wd, 32'h5a5a_0008);
        send("lw8b", 0, 2'b10, 0, 32'h8, 32'h0, 32'h5a5a_0008, 0, 3, 1, 0);
        send("swtop", 1, 2'b10, 0, 32'hffc, 32'hcafe_f00d, 32'h0, 0, 2, 0, 1);
        chk("swtop_waddr", last_wa, 32'd1023);
        send("lwtop", 0, 2'b10, 0, 32'hffc, 32'h0, 32'hcafe_f00d, 0, 3, 1, 0);

        send("e_lh3", 0, 2'b01, 0, 32'h3, 32'h0, 32'h0, 1, 1, 0, 0);
        send("e_sw6", 1, 2'b10, 0, 32'h6, 32'hffff_ffff, 32'h0, 1, 1, 0, 0);
        send("e_sz3", 0, 2'b11, 0, 32'h8, 32'h0, 32'h0, 1, 1, 0, 0);
        send("e_oor", 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, 1, 0, 0);
        send("lw8c", 0, 2'b10, 0, 32'h8, 32'h0, 32'h5a5a_0008, 0, 3, 1, 0);

        @(negedge clk);
        s0 = rsp_cnt;
        req_valid = 1'b1;
        req_store = 1'b0;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = 32'h8;
        exp_q.push_back('{"b2b_a", 32'h5a5a_0008, 1'b0, 3});
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            req_store = 1'b1;
            req_size = 2'b10;
            req_addr = $urandom_range(0, 1023) * 4;
            req_wdata = $urandom;
            @(negedge clk);
            k++;
        end
        chk("b2b_ready", 32'(req_ready), 32'd1);
        req_store = 1'b0;
        req_size = 2'b10;
        req_addr = 32'h14;
        exp_q.push_back('{"b2b_b", 32'h12ab_80ff, 1'b0, 3});
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (rsp_cnt < s0 + 2 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("b2b_count", 32'(rsp_cnt - s0), 32'd2);
        send("b2b_chk8", 0, 2'b10, 0, 32'h8, 32'h0, 32'h5a5a_0008, 0, 3, 1, 0);

        @(negedge clk);
        w0 = wr_cnt;
        s0 = rsp_cnt;
        req_valid = 1'b1;
        req_store = 1'b1;
        req_size = 2'b00;
        req_addr = 32'h15;
        req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_read", 32'(read_enable), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_we", 32'(write_enable), 32'd0);
        chk("rst_mid_re", 32'(read_enable), 32'd0);
        chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mid_nowrite", 32'(wr_cnt - w0), 32'd0);
        chk("rst_mid_norsp", 32'(rsp_cnt - s0), 32'd0);
        send("post_rst_lw", 0, 2'b10, 0, 32'h14, 32'h0, 32'h12ab_80ff, 0, 3, 1, 0);
        send("post_rst_sb", 1, 2'b00, 0, 32'h15, 32'h77, 32'h0, 0, 4, 1, 1);
        send("post_rst_lw2", 0, 2'b10, 0, 32'h14, 32'h0, 32'h12ab_77ff, 0, 3, 1, 0);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
